riscv_multicycle_ctrl: RTL
==========================

# riscv_multicycle_ctrl

Main control FSM for the multi-cycle RV32I core. It sequences the shared ALU, register file, PC/IR registers and the single unified memory port. Once per instruction it walks fetch → decode → execute → memory → writeback, and it drives `ALUOp` to the ALU control unit. It also counts retired instructions and halts on illegal opcodes.

## Interface
Parameters:
- `INSTRET_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1: core clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `opcode`  in  7: instr[6:0], taken from the IR.
- `func3`  in  3: instr[14:12], taken from the IR.
- `alu_zero`, `alu_lt`, `alu_ltu`  in  1 each: ALU flags from the current SUB.
- `mem_ready`  in  1: memory completion; one-cycle pulse while `mem_req` is high.
- `mem_req`  out  1: memory access request.
- `mem_we`  out  1: write enable, valid with `mem_req`.
- `adr_src`  out  1: memory address select; 0 = PC, 1 = ALU result register.
- `ir_write`  out  1: load IR, and capture old PC.
- `pc_write`  out  1: load PC from the `result_src` mux.
- `reg_write`  out  1: register-file write.
- `alu_op`  out  2: 00 R-type, 01 branch (SUB), 10 address (ADD), 11 I-type arithmetic.
- `alu_src_a`  out  2: 00 PC, 01 old PC, 10 rs1.
- `alu_src_b`  out  2: 00 rs2, 01 immediate, 10 constant 4.
- `result_src`  out  2: 00 ALU result register, 01 memory data, 10 live ALU output.
- `retire`  out  1: one-cycle pulse when an instruction completes.
- `instret`  out  `INSTRET_W`: retired-instruction count.
- `halt`  out  1: illegal opcode trapped; sticky until reset.

## Operation
- States: IDLE, FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, JALR, LUI, AUIPC, TRAP.
- IDLE: entered on reset; goes to FETCH unconditionally on the next cycle.
- FETCH: `mem_req`=1, `adr_src`=0.
  - Stays in FETCH until `mem_ready`.
  - On `mem_ready`: `ir_write`=1 and `pc_write`=1, with PC ← PC+4 (a_src 00, b_src 10, `alu_op` 10, result_src 10).
- DECODE: ALU computes old PC + imm (branch/JAL target, latched). Next state by opcode:
  - 0000011 / 0100011 → MEM_ADR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - 0010111 → AUIPC
  - any other opcode → TRAP
- MEM_ADR: rs1 + imm with `alu_op` 10. Goes to MEM_RD for loads and MEM_WR for stores.
- MEM_RD: `mem_req`=1, `adr_src`=1. Waits for `mem_ready`, then goes to MEM_WB.
- MEM_WB: `reg_write`=1, result_src 01, `retire`. Goes to FETCH.
- MEM_WR: `mem_req`=1, `mem_we`=1, `adr_src`=1. On `mem_ready`: `retire`, then FETCH.
- EXEC_R: `alu_op` 00, rs1 op rs2. Goes to ALU_WB.
- EXEC_I: `alu_op` 11, rs1 op imm. Goes to ALU_WB.
- ALU_WB: `reg_write`=1, result_src 00, `retire`. Goes to FETCH.
- BRANCH: rs1 − rs2 with `alu_op` 01. `retire`, then FETCH.
  - Taken condition by func3: 000 `alu_zero`; 001 !`alu_zero`; 100 `alu_lt`; 101 !`alu_lt`; 110 `alu_ltu`; 111 !`alu_ltu`.
  - If taken: `pc_write`=1, result_src 00 (the target latched in DECODE).
  - func3 010/011 → TRAP.
- JAL: `pc_write` from the latched target; ALU computes old PC + 4. Goes to ALU_WB.
- JALR: ALU computes rs1 + imm; `pc_write`=1, result_src 10. Goes to ALU_WB. The rd value is old PC + 4, produced by the datapath link register.
- LUI: `alu_src_b` 01, `alu_op` 10 with src_a zeroed by the datapath. Goes to ALU_WB.
- AUIPC: old PC + imm. Goes to ALU_WB.
- TRAP: `halt`=1; all enables 0; no exit except reset.
- `instret`: increments by 1 on each `retire`; wraps from all-ones to 0.

## Timing
- Reset: while `rst_n` is low, every output is 0 (`instret`=0, `halt`=0) and state = IDLE.
- Outputs are Moore decodes of the state. Exceptions: the FETCH/MEM `ir_write`/`pc_write`/`retire` terms and the BRANCH `pc_write` are combinational on `mem_ready` and the flags.
- Cycles per instruction with zero memory wait (FETCH→FETCH):
  - R/I/LUI/AUIPC/JAL/JALR: 4
  - branch: 3
  - store: 4
  - load: 5
- Each memory wait cycle adds 1.
- `mem_req` holds steady until `mem_ready`; address select must not change while it is high.
- `mem_ready` outside FETCH/MEM_RD/MEM_WR is ignored.
- Reset asserted mid-access drops `mem_req` asynchronously; the partial instruction is not retired.

## Structure
- Shared package `riscv_pkg`:
  - opcode localparams
  - `alu_op` encodings (ALUOP_R, ALUOP_BR, ALUOP_ADD, ALUOP_I)
  - src/result select encodings
  - state encoding
- One natural sub-module, `riscv_branch_cond`: combinational func3 + flags → taken.

## Test plan
- Reset, then `add` opcode 0110011 with `mem_ready` on the first FETCH cycle:
  - states IDLE, FETCH, DECODE, EXEC_R, ALU_WB
  - `alu_op`=00 in EXEC_R
  - `retire` at cycle 4 after FETCH
  - `instret`=1
- Load 0000011 with `mem_ready` delayed 3 cycles in both FETCH and MEM_RD:
  - `mem_req` held high throughout each wait
  - `adr_src` 0 then 1
  - 11 cycles total
  - `reg_write` with result_src 01
- Branch func3=001 with `alu_zero`=0 → `pc_write` in BRANCH. Repeat with `alu_zero`=1 → no `pc_write`. Both retire in 3 cycles.
- Opcode 0000000 → TRAP after DECODE:
  - `halt`=1 and all enables 0 for 20 cycles
  - `mem_ready` pulses ignored
  - `rst_n` low clears `halt`
- Drop `rst_n` during MEM_WR wait → `mem_req`/`mem_we` fall immediately with no clock edge; `instret` unchanged.
- Preload `instret` to all-ones via 2^n retires (or force with `INSTRET_W`=4, 16 retires) → wraps to 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RV32I core: opcodes, ALU/mux selects,
// main-FSM states and the per-state control word.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] ALUOP_R   = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_ADD = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUREG = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_EXEC_R,
        S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC, S_TRAP
    } state_t;

    // Registered (Moore) part of the control word; the mem_ready/flag terms are added in the top.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       adr_src;
        logic       reg_write;
        logic       pc_write;
        logic       retire;
        logic       halt;
        logic [1:0] alu_op;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
    } ctrl_t;

    function automatic state_t decode_next(input logic [6:0] op);
        state_t s;
        case (op)
            OP_LOAD, OP_STORE: s = S_MEM_ADR;
            OP_R:              s = S_EXEC_R;
            OP_I:              s = S_EXEC_I;
            OP_BRANCH:         s = S_BRANCH;
            OP_JAL:            s = S_JAL;
            OP_JALR:           s = S_JALR;
            OP_LUI:            s = S_LUI;
            OP_AUIPC:          s = S_AUIPC;
            default:           s = S_TRAP;
        endcase
        return s;
    endfunction

    function automatic ctrl_t moore_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req    = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.result_src = RES_ALU;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.result_src = RES_MEM;
                c.retire     = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_req = 1'b1;
                c.mem_we  = 1'b1;
                c.adr_src = 1'b1;
            end
            S_EXEC_R: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALUOP_R;
            end
            S_EXEC_I: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_I;
            end
            S_ALU_WB: begin
                c.reg_write  = 1'b1;
                c.result_src = RES_ALUREG;
                c.retire     = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a  = SRCA_RS1;
                c.alu_src_b  = SRCB_RS2;
                c.alu_op     = ALUOP_BR;
                c.result_src = RES_ALUREG;
            end
            S_JAL: begin
                c.pc_write   = 1'b1;
                c.result_src = RES_ALUREG;
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
            end
            S_JALR: begin
                c.pc_write   = 1'b1;
                c.result_src = RES_ALU;
                c.alu_src_a  = SRCA_RS1;
                c.alu_src_b  = SRCB_IMM;
                c.alu_op     = ALUOP_ADD;
            end
            S_LUI: begin
                // The datapath forces operand A to zero for LUI.
                c.alu_src_a = SRCA_PC;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_AUIPC: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_TRAP:  c.halt = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/riscv_branch_cond.sv
// Branch resolution: maps func3 and the SUB flags to taken/legal.
module riscv_branch_cond
    import riscv_pkg::*;
(
    input  logic [2:0] func3,
    input  logic       alu_zero,
    input  logic       alu_lt,
    input  logic       alu_ltu,
    output logic       taken,
    output logic       legal
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        taken = 1'b0;
        legal = 1'b1;
        case (func3)
            F3_BEQ:  taken = alu_zero;
            F3_BNE:  taken = !alu_zero;
            F3_BLT:  taken = alu_lt;
            F3_BGE:  taken = !alu_lt;
            F3_BLTU: taken = alu_ltu;
            F3_BGEU: taken = !alu_ltu;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch/decode/execute/
// memory/writeback, counts retired instructions and traps on illegal encodings.
module riscv_multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic [2:0]           func3,
    input  logic                 alu_zero,
    input  logic                 alu_lt,
    input  logic                 alu_ltu,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 adr_src,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic [1:0]           alu_op,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           result_src,
    output logic                 retire,
    output logic [INSTRET_W-1:0] instret,
    output logic                 halt
);

    state_t state, nxt;
    ctrl_t  ctrl_q;
    logic   br_taken, br_legal;

    riscv_branch_cond u_branch_cond (
        .func3    (func3),
        .alu_zero (alu_zero),
        .alu_lt   (alu_lt),
        .alu_ltu  (alu_ltu),
        .taken    (br_taken),
        .legal    (br_legal)
    );

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:    nxt = S_FETCH;
            S_FETCH:   if (mem_ready) nxt = S_DECODE;
            S_DECODE:  nxt = decode_next(opcode);
            S_MEM_ADR: nxt = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:  if (mem_ready) nxt = S_MEM_WB;
            S_MEM_WB:  nxt = S_FETCH;
            S_MEM_WR:  if (mem_ready) nxt = S_FETCH;
            S_EXEC_R, S_EXEC_I, S_JAL, S_JALR, S_LUI, S_AUIPC: nxt = S_ALU_WB;
            S_ALU_WB:  nxt = S_FETCH;
            S_BRANCH:  nxt = br_legal ? S_FETCH : S_TRAP;
            S_TRAP:    nxt = S_TRAP;
            default:   nxt = S_TRAP;
        endcase
    end

    // Control word is registered from the next state, so it is valid from the
    // first cycle of each state and clears asynchronously with rst_n.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            ctrl_q <= '0;
        end else begin
            state  <= nxt;
            ctrl_q <= moore_ctrl(nxt);
        end
    end

    assign mem_req    = ctrl_q.mem_req;
    assign mem_we     = ctrl_q.mem_we;
    assign adr_src    = ctrl_q.adr_src;
    assign reg_write  = ctrl_q.reg_write;
    assign alu_op     = ctrl_q.alu_op;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign result_src = ctrl_q.result_src;
    assign halt       = ctrl_q.halt;

    // Handshake- and flag-dependent terms stay combinational.
    assign ir_write = (state == S_FETCH) && mem_ready;
    assign pc_write = ctrl_q.pc_write
                    || ((state == S_FETCH) && mem_ready)
                    || ((state == S_BRANCH) && br_legal && br_taken);
    assign retire   = ctrl_q.retire
                    || ((state == S_MEM_WR) && mem_ready)
                    || ((state == S_BRANCH) && br_legal);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            instret <= '0;
        else if (retire)
            instret <= instret + INSTRET_W'(1);
    end

endmodule
